// File: rtl/ysyx_23060136_exu_mdu_ctrl.sv
// EX-stage sequencer for the external multiplier and divider units.
// Optional: YSYX_23060136_MDU_DIVZERO_BYPASS_EN resolves divide-by-zero locally.
module ysyx_23060136_exu_mdu_ctrl #(
   parameter int BITS_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              op_mul,
   input  logic              op_div,
   input  logic              op_rem,
   input  logic              op_hi,
   input  logic              op_lo,
   input  logic              op_u,
   input  logic              op_s,
   input  logic              op_su,
   input  logic              op_word,
   input  logic [BITS_W-1:0] da_i,
   input  logic [BITS_W-1:0] db_i,
   output logic              busy_o,
   output logic              res_valid_o,
   output logic [BITS_W-1:0] res_o,
   output logic              flush_o,
   output logic              mul_valid,
   output logic              mulw,
   output logic [1:0]        mul_signed,
   output logic [BITS_W-1:0] multiplicand,
   output logic [BITS_W-1:0] multiplier,
   input  logic              mul_ready,
   input  logic              mul_out_valid,
   input  logic [BITS_W-1:0] result_hi,
   input  logic [BITS_W-1:0] result_lo,
   output logic              div_valid,
   output logic              divw,
   output logic              div_signed,
   output logic [BITS_W-1:0] dividend,
   output logic [BITS_W-1:0] divisor,
   input  logic              div_ready,
   input  logic              div_out_valid,
   input  logic [BITS_W-1:0] quotient,
   input  logic [BITS_W-1:0] remainder
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MREQ  = 3'd1;
   localparam logic [2:0] MWAIT = 3'd2;
   localparam logic [2:0] DREQ  = 3'd3;
   localparam logic [2:0] DWAIT = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic              q_mul, q_div, q_rem, q_hi, q_lo;
   logic              q_u, q_s, q_su, q_word;
   logic [BITS_W-1:0] a_q, b_q, res_q;
   logic              start;
   logic              div_zero;
   logic [BITS_W-1:0] zero_res;
   logic [BITS_W-1:0] mul_sel, div_sel;
   logic [BITS_W-1:0] mul_cap, div_cap;

   function automatic logic [BITS_W-1:0] sext_w(input logic [BITS_W-1:0] r);
      return {{(BITS_W-32){r[31]}}, r[31:0]};
   endfunction

   assign start = (op_mul | op_div | op_rem) & ~flush_i;

`ifdef YSYX_23060136_MDU_DIVZERO_BYPASS_EN
   assign div_zero = (op_div | op_rem) & ~op_mul &
                     (op_word ? (db_i[31:0] == 32'd0) : (db_i == '0));
   assign zero_res = op_rem ? (op_word ? sext_w(da_i) : da_i) : '1;
`else
   assign div_zero = 1'b0;
   assign zero_res = '0;
`endif

   assign mul_sel = (q_hi & ~q_lo) ? result_hi : result_lo;
   assign div_sel = q_rem ? remainder : quotient;
   assign mul_cap = q_word ? sext_w(mul_sel) : mul_sel;
   assign div_cap = q_word ? sext_w(div_sel) : div_sel;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (op_mul)        state_nx = MREQ;
               else if (div_zero) state_nx = DONE;
               else               state_nx = DREQ;
            end
         end
         MREQ: begin
            if (flush_i)        state_nx = IDLE;
            else if (mul_ready) state_nx = MWAIT;
         end
         MWAIT: begin
            if (flush_i)            state_nx = IDLE;
            else if (mul_out_valid) state_nx = DONE;
         end
         DREQ: begin
            if (flush_i)        state_nx = IDLE;
            else if (div_ready) state_nx = DWAIT;
         end
         DWAIT: begin
            if (flush_i)            state_nx = IDLE;
            else if (div_out_valid) state_nx = DONE;
         end
         DONE: begin
            if (flush_i || !stall_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         q_mul  <= 1'b0;
         q_div  <= 1'b0;
         q_rem  <= 1'b0;
         q_hi   <= 1'b0;
         q_lo   <= 1'b0;
         q_u    <= 1'b0;
         q_s    <= 1'b0;
         q_su   <= 1'b0;
         q_word <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            q_mul  <= op_mul;
            q_div  <= op_div;
            q_rem  <= op_rem;
            q_hi   <= op_hi;
            q_lo   <= op_lo;
            q_u    <= op_u;
            q_s    <= op_s;
            q_su   <= op_su;
            q_word <= op_word;
            a_q    <= da_i;
            b_q    <= db_i;
            if (div_zero) res_q <= zero_res;
         end
         // Result is captured only from the wait states; stray out_valid is dropped.
         if (state == MWAIT && mul_out_valid && !flush_i) res_q <= mul_cap;
         if (state == DWAIT && div_out_valid && !flush_i) res_q <= div_cap;
      end
   end

   assign busy_o = (state == IDLE && start) ||
                   state == MREQ || state == MWAIT ||
                   state == DREQ || state == DWAIT;
   assign res_valid_o = (state == DONE);
   assign res_o       = res_q;
   assign flush_o     = flush_i & (state != IDLE);

   assign mul_valid    = (state == MREQ);
   assign mulw         = q_word & q_mul;
   assign mul_signed   = {q_s | q_su, q_s};
   assign multiplicand = a_q;
   assign multiplier   = b_q;

   assign div_valid  = (state == DREQ);
   assign divw       = q_word & (q_div | q_rem);
   assign div_signed = (q_div | q_rem) & ~q_u;
   assign dividend   = a_q;
   assign divisor    = b_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_mdu_ctrl.sv
// Bench for ysyx_23060136_exu_mdu_ctrl: vector table driven through
// behavioural multiplier/divider stubs, plus flush and stall sequences.
module tb_ysyx_23060136_exu_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i, stall_i;
   logic        op_mul, op_div, op_rem, op_hi, op_lo;
   logic        op_u, op_s, op_su, op_word;
   logic [63:0] da_i, db_i;
   logic        busy_o, res_valid_o, flush_o;
   logic [63:0] res_o;
   logic        mul_valid, mulw;
   logic [1:0]  mul_signed;
   logic [63:0] multiplicand, multiplier;
   logic        mul_ready, mul_out_valid;
   logic [63:0] result_hi, result_lo;
   logic        div_valid, divw, div_signed;
   logic [63:0] dividend, divisor;
   logic        div_ready, div_out_valid;
   logic [63:0] quotient, remainder;

   ysyx_23060136_exu_mdu_ctrl #(.BITS_W(64)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
      .op_mul(op_mul), .op_div(op_div), .op_rem(op_rem),
      .op_hi(op_hi), .op_lo(op_lo), .op_u(op_u), .op_s(op_s),
      .op_su(op_su), .op_word(op_word), .da_i(da_i), .db_i(db_i),
      .busy_o(busy_o), .res_valid_o(res_valid_o), .res_o(res_o),
      .flush_o(flush_o), .mul_valid(mul_valid), .mulw(mulw),
      .mul_signed(mul_signed), .multiplicand(multiplicand),
      .multiplier(multiplier), .mul_ready(mul_ready),
      .mul_out_valid(mul_out_valid), .result_hi(result_hi),
      .result_lo(result_lo), .div_valid(div_valid), .divw(divw),
      .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
      .div_ready(div_ready), .div_out_valid(div_out_valid),
      .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mul, div, rem, hi, lo, u, s, su, word;
      logic [63:0] a, b;
      logic [63:0] r0;   // result_hi or quotient from the unit stub
      logic [63:0] r1;   // result_lo or remainder from the unit stub
      int          rdly, odly;
      logic [1:0]  msgn;
      logic [63:0] exp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] kind, input logic hi,
                               input logic [2:0] sgn, input logic word,
                               input logic [63:0] a, b, r0, r1,
                               input int rdly, odly,
                               input logic [63:0] exp);
      vec_t v;
      v.mul = kind[2]; v.div = kind[1]; v.rem = kind[0];
      v.hi = hi; v.lo = kind[2] & ~hi;
      v.u = sgn[2]; v.s = sgn[1]; v.su = sgn[0];
      v.word = word; v.a = a; v.b = b; v.r0 = r0; v.r1 = r1;
      v.rdly = rdly; v.odly = odly;
      v.msgn = sgn[1] ? 2'b11 : (sgn[0] ? 2'b10 : 2'b00);
      v.exp = exp;
      return v;
   endfunction

   function automatic logic unit_valid(input logic is_mul);
      return is_mul ? mul_valid : div_valid;
   endfunction

   task automatic clear_ops();
      op_mul = 0; op_div = 0; op_rem = 0; op_hi = 0; op_lo = 0;
      op_u = 0; op_s = 0; op_su = 0; op_word = 0;
   endtask

   task automatic do_op(input vec_t v, input int stall_n);
      int          n;
      logic [63:0] want;
      @(negedge clk);
      op_mul = v.mul; op_div = v.div; op_rem = v.rem;
      op_hi = v.hi; op_lo = v.lo; op_u = v.u; op_s = v.s;
      op_su = v.su; op_word = v.word; da_i = v.a; db_i = v.b;
      #1;
      chk("busy_start", busy_o, 1);
      exp_q.push_back(v.exp);
      @(negedge clk);
      clear_ops();
      da_i = {$urandom, $urandom};
      db_i = {$urandom, $urandom};
      n = 0;
      while (unit_valid(v.mul) !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("req_latency", n, 0);
      chk("other_valid", v.mul ? div_valid : mul_valid, 0);
      chk("opnd_a", v.mul ? multiplicand : dividend, v.a);
      chk("opnd_b", v.mul ? multiplier : divisor, v.b);
      if (v.mul) begin
         chk("mul_signed", mul_signed, v.msgn);
         chk("mulw", mulw, v.word);
      end else begin
         chk("div_signed", div_signed, !v.u);
         chk("divw", divw, v.word);
      end
      for (int k = 0; k < v.rdly; k++) begin
         mul_out_valid = 1; div_out_valid = 1;
         result_hi = JUNK; result_lo = JUNK;
         quotient = JUNK; remainder = JUNK;
         da_i = {$urandom, $urandom};
         @(negedge clk);
         chk("req_hold", unit_valid(v.mul), 1);
         chk("req_opnd", v.mul ? multiplicand : dividend, v.a);
      end
      mul_out_valid = 0; div_out_valid = 0;
      if (v.mul) mul_ready = 1;
      else       div_ready = 1;
      @(negedge clk);
      mul_ready = 0; div_ready = 0;
      for (int k = 0; k < v.odly; k++) begin
         @(negedge clk);
         chk("wait_busy", busy_o, 1);
         chk("wait_novalid", res_valid_o, 0);
      end
      if (v.mul) begin
         mul_out_valid = 1; result_hi = v.r0; result_lo = v.r1;
      end else begin
         div_out_valid = 1; quotient = v.r0; remainder = v.r1;
      end
      stall_i = (stall_n > 0);
      @(negedge clk);
      mul_out_valid = 0; div_out_valid = 0;
      result_hi = JUNK; result_lo = JUNK;
      quotient = JUNK; remainder = JUNK;
      n = 0;
      while (res_valid_o !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         chk("res_timeout", 0, 1);
      end else begin
         want = exp_q.pop_front();
         chk("res_latency", n, 0);
         chk("res", res_o, want);
         chk("done_busy", busy_o, 0);
         for (int k = 0; k < stall_n; k++) begin
            @(negedge clk);
            chk("stall_valid", res_valid_o, 1);
            chk("stall_res", res_o, want);
         end
      end
      stall_i = 0;
      @(negedge clk);
      chk("idle_after", res_valid_o, 0);
   endtask

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL global_timeout act=1 exp=0");
      $fatal(1, "timeout");
   end

   initial begin
      // kind: {mul,div,rem}; sgn: {u,s,su}
      vecs[0] = mk(3'b100, 0, 3'b010, 0, 64'd3, -64'sd2,
                   '1, 64'hFFFF_FFFF_FFFF_FFFA, 0, 0,
                   64'hFFFF_FFFF_FFFF_FFFA);
      vecs[1] = mk(3'b100, 1, 3'b100, 0, '1, 64'd2,
                   64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 2, 1, 64'h1);
      vecs[2] = mk(3'b010, 0, 3'b010, 1, -64'sd7, 64'd2,
                   64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF,
                   0, 2, 64'hFFFF_FFFF_FFFF_FFFD);
      vecs[3] = mk(3'b001, 0, 3'b010, 1, -64'sd7, 64'd2,
                   64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF,
                   1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      vecs[4] = mk(3'b100, 0, 3'b001, 1, 64'd5, 64'h1_0000_0007,
                   64'h0, 64'h1234_5678_8000_0000, 0, 0,
                   64'hFFFF_FFFF_8000_0000);
      vecs[5] = mk(3'b010, 0, 3'b100, 0, 64'd100, 64'd7,
                   64'd14, 64'd2, 1, 1, 64'd14);
      vecs[6] = mk(3'b001, 0, 3'b100, 0, 64'd100, 64'd7,
                   64'd14, 64'd2, 0, 0, 64'd2);

      rst = 1; flush_i = 0; stall_i = 0; clear_ops();
      da_i = 0; db_i = 0;
      mul_ready = 0; mul_out_valid = 0; result_hi = 0; result_lo = 0;
      div_ready = 0; div_out_valid = 0; quotient = 0; remainder = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", res_valid_o, 0);
      chk("rst_res", res_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_uvalid", {mul_valid, div_valid}, 0);
      chk("rst_sign", {mul_signed, div_signed, mulw, divw}, 0);
      chk("rst_opnd", multiplicand | multiplier | dividend | divisor, 0);
      rst = 0;

      for (int i = 0; i < 7; i++) do_op(vecs[i], 0);

      // stall in DONE: result held for four cycles
      do_op(vecs[0], 3);

      // flush in MWAIT, then a late out_valid that must be ignored
      @(negedge clk);
      op_mul = 1; op_s = 1; op_lo = 1; da_i = 64'd9; db_i = 64'd9;
      @(negedge clk);
      clear_ops();
      chk("fl_mvalid", mul_valid, 1);
      mul_ready = 1;
      @(negedge clk);
      mul_ready = 0;
      flush_i = 1;
      #1;
      chk("fl_pulse", flush_o, 1);
      @(negedge clk);
      flush_i = 0;
      #1;
      chk("fl_pulse_end", flush_o, 0);
      chk("fl_idle_busy", busy_o, 0);
      mul_out_valid = 1; result_lo = 64'd81;
      @(negedge clk);
      mul_out_valid = 0;
      repeat (3) begin
         chk("fl_no_valid", res_valid_o, 0);
         @(negedge clk);
      end

      // flush together with start in IDLE
      op_div = 1; da_i = 64'd4; db_i = 64'd2; flush_i = 1;
      #1;
      chk("fl_start_flush_o", flush_o, 0);
      @(negedge clk);
      clear_ops(); flush_i = 0;
      chk("fl_start_dvalid", div_valid, 0);
      chk("fl_start_busy", busy_o, 0);

      // flush in DONE
      op_div = 1; op_u = 1; da_i = 64'd9; db_i = 64'd2;
      @(negedge clk);
      clear_ops(); div_ready = 1;
      @(negedge clk);
      div_ready = 0; div_out_valid = 1; quotient = 64'd4;
      @(negedge clk);
      div_out_valid = 0;
      chk("fd_valid", res_valid_o, 1);
      chk("fd_res", res_o, 64'd4);
      stall_i = 1; flush_i = 1;
      #1;
      chk("fd_pulse", flush_o, 1);
      @(negedge clk);
      flush_i = 0; stall_i = 0;
      chk("fd_no_valid", res_valid_o, 0);

      // divide by zero
`ifdef YSYX_23060136_MDU_DIVZERO_BYPASS_EN
      @(negedge clk);
      op_div = 1; op_u = 1; da_i = 64'd5; db_i = 64'd0;
      @(negedge clk);
      clear_ops();
      chk("dz_dvalid", div_valid, 0);
      chk("dz_valid", res_valid_o, 1);
      chk("dz_res", res_o, '1);
      @(negedge clk);
      chk("dz_idle", res_valid_o, 0);
`else
      do_op(mk(3'b010, 0, 3'b100, 0, 64'd5, 64'd0, '1, 64'd5,
               0, 0, '1), 0);
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
